// File: rtl/commit_agg_mpu_if.sv
// Commit aggregator bus: issue registration, per-lane completion reports,
// and the commit request / status outputs toward the MPU commit table.
interface commit_agg_mpu_if #(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_LANE  = 8,
  parameter int WIDTH_NO  = $clog2(NUM_ENTRY)
);
  logic                               I_Req_Issue;
  logic [WIDTH_NO-1:0]                I_Issue_No;
  logic [NUM_LANE-1:0]                I_Lane_Mask;
  logic [NUM_LANE-1:0]                I_Lane_Done;
  logic [NUM_LANE-1:0][WIDTH_NO-1:0]  I_Lane_No;
  logic                               O_Req_Commit;
  logic [WIDTH_NO-1:0]                O_CommitNo;
  logic                               O_Busy;
  logic                               O_Err;

  // Dispatch/lane side drives requests and observes commits.
  modport master (
    output I_Req_Issue, I_Issue_No, I_Lane_Mask, I_Lane_Done, I_Lane_No,
    input  O_Req_Commit, O_CommitNo, O_Busy, O_Err
  );

  // Aggregator side.
  modport slave (
    input  I_Req_Issue, I_Issue_No, I_Lane_Mask, I_Lane_Done, I_Lane_No,
    output O_Req_Commit, O_CommitNo, O_Busy, O_Err
  );
endinterface

// File: rtl/commit_agg_mpu.sv
// Commit aggregator for the MPU. Tracks, per issue number, which lanes
// still owe a completion and emits one commit request per fully completed
// entry, choosing among ready entries round-robin, one per cycle.
module commit_agg_mpu #(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_LANE  = 8,
  parameter int WIDTH_NO  = $clog2(NUM_ENTRY)
) (
  input  logic            clock,
  input  logic            reset,
  commit_agg_mpu_if.slave bus
);

  typedef logic [WIDTH_NO-1:0] mpu_issue_no_t;

  // Registered state
  logic [NUM_ENTRY-1:0]                r_valid;
  logic [NUM_ENTRY-1:0][NUM_LANE-1:0]  r_pending;
  mpu_issue_no_t                       r_rr;
  logic                                r_commit;
  mpu_issue_no_t                       r_commit_no;
  logic                                r_err;

  // Combinational next-state and grant
  logic [NUM_ENTRY-1:0]                w_ready;
  logic [NUM_ENTRY-1:0]                w_valid_nxt;
  logic [NUM_ENTRY-1:0][NUM_LANE-1:0]  w_pending_nxt;
  logic                                w_grant;
  mpu_issue_no_t                       w_grant_no;
  logic                                w_err;

  // An entry is ready once it is live and no lane still owes a completion.
  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      w_ready[i] = r_valid[i] & ~(|r_pending[i]);
    end
  end

  // Round-robin search: first ready entry at or above r_rr, wrapping.
  // The index arithmetic wraps naturally because NUM_ENTRY is a power of two.
  always_comb begin
    mpu_issue_no_t idx;
    w_grant    = 1'b0;
    w_grant_no = r_rr;
    for (int k = 0; k < NUM_ENTRY; k++) begin
      idx = r_rr + mpu_issue_no_t'(k);
      if (!w_grant && w_ready[idx]) begin
        w_grant    = 1'b1;
        w_grant_no = idx;
      end
    end
  end

  // Entry table update: completions, grant retirement, new issue, error flag.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred when a branch leaves it untouched.
  always_comb begin
    w_valid_nxt   = r_valid;
    w_pending_nxt = r_pending;
    w_err         = 1'b0;

    // Completions judged against registered state: a done that lands on an
    // entry being issued this same cycle sees Valid=0 and is rejected.
    for (int l = 0; l < NUM_LANE; l++) begin
      if (bus.I_Lane_Done[l]) begin
        if (!r_valid[bus.I_Lane_No[l]] || !r_pending[bus.I_Lane_No[l]][l]) begin
          w_err = 1'b1;
        end else begin
          w_pending_nxt[bus.I_Lane_No[l]][l] = 1'b0;
        end
      end
    end

    // A granted entry has Pending==0, so no completion above touched it.
    if (w_grant) begin
      w_valid_nxt[w_grant_no] = 1'b0;
    end

    // Issue only lands on a free entry; a free entry is never the grantee.
    if (bus.I_Req_Issue) begin
      if (r_valid[bus.I_Issue_No]) begin
        w_err = 1'b1;
      end else begin
        w_valid_nxt[bus.I_Issue_No]   = 1'b1;
        w_pending_nxt[bus.I_Issue_No] = bus.I_Lane_Mask;
      end
    end
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the pending table is reset along with Valid; it is small flop
  // storage, and a known-zero table keeps the reset state fully defined.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid     <= '0;
      r_pending   <= '0;
      r_rr        <= '0;
      r_commit    <= 1'b0;
      r_commit_no <= '0;
      r_err       <= 1'b0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_pending <= w_pending_nxt;
      r_commit  <= w_grant;
      r_err     <= w_err;
      if (w_grant) begin
        r_commit_no <= w_grant_no;
        r_rr        <= w_grant_no + mpu_issue_no_t'(1);
      end
    end
  end

  assign bus.O_Req_Commit = r_commit;
  assign bus.O_CommitNo   = r_commit_no;
  assign bus.O_Busy       = |r_valid;
  assign bus.O_Err        = r_err;

endmodule

// File: tb/tb_commit_agg_mpu.sv
// Directed testbench for commit_agg_mpu. Inputs are driven just after a
// rising edge; outputs are sampled 1ns after the edge that produced them.
module tb_commit_agg_mpu;
  localparam int NUM_ENTRY = 16;
  localparam int NUM_LANE  = 8;
  localparam int WIDTH_NO  = $clog2(NUM_ENTRY);

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  commit_agg_mpu_if #(.NUM_ENTRY(NUM_ENTRY), .NUM_LANE(NUM_LANE), .WIDTH_NO(WIDTH_NO)) bus ();

  commit_agg_mpu #(.NUM_ENTRY(NUM_ENTRY), .NUM_LANE(NUM_LANE), .WIDTH_NO(WIDTH_NO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic clear_inputs();
    bus.I_Req_Issue = 1'b0;
    bus.I_Issue_No  = '0;
    bus.I_Lane_Mask = '0;
    bus.I_Lane_Done = '0;
    bus.I_Lane_No   = '0;
  endtask

  // Advance one edge, then withdraw all one-shot inputs.
  task automatic tick();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic drive_issue(input int no, input logic [NUM_LANE-1:0] mask);
    bus.I_Req_Issue = 1'b1;
    bus.I_Issue_No  = WIDTH_NO'(no);
    bus.I_Lane_Mask = mask;
  endtask

  task automatic drive_done(input int lane, input int no);
    bus.I_Lane_Done[lane] = 1'b1;
    bus.I_Lane_No[lane]   = WIDTH_NO'(no);
  endtask

  // Compare commit strobe / number / error against expectations.
  task automatic expect_out(input string name, input logic commit,
                            input int no, input logic err);
    n_tests++;
    if (bus.O_Req_Commit !== commit) begin
      n_fail++;
      $display("FAIL %s commit: got %b want %b", name, bus.O_Req_Commit, commit);
    end
    if (commit) begin
      n_tests++;
      if (bus.O_CommitNo !== WIDTH_NO'(no)) begin
        n_fail++;
        $display("FAIL %s commit_no: got %0d want %0d", name, bus.O_CommitNo, no);
      end
    end
    n_tests++;
    if (bus.O_Err !== err) begin
      n_fail++;
      $display("FAIL %s err: got %b want %b", name, bus.O_Err, err);
    end
  endtask

  task automatic expect_busy(input string name, input logic busy);
    n_tests++;
    if (bus.O_Busy !== busy) begin
      n_fail++;
      $display("FAIL %s busy: got %b want %b", name, bus.O_Busy, busy);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({bus.O_Req_Commit, bus.O_CommitNo, bus.O_Busy, bus.O_Err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got commit=%b no=%0d busy=%b err=%b want all 0",
               bus.O_Req_Commit, bus.O_CommitNo, bus.O_Busy, bus.O_Err);
    end
    reset = 1'b0;
    tick();
    expect_out("reset_idle", 1'b0, 0, 1'b0);
  endtask

  // No=3 mask 05: lane0 then lane2 two cycles later; commit after the next edge.
  task automatic test_basic();
    drive_issue(3, 8'h05);
    tick();
    expect_out("basic_issue", 1'b0, 0, 1'b0);
    expect_busy("basic_issue", 1'b1);
    drive_done(0, 3);
    tick();
    expect_out("basic_lane0", 1'b0, 0, 1'b0);
    tick();
    tick();
    expect_out("basic_wait", 1'b0, 0, 1'b0);
    drive_done(2, 3);
    tick();
    expect_out("basic_lane2_edge", 1'b0, 0, 1'b0);
    tick();
    expect_out("basic_commit", 1'b1, 3, 1'b0);
    expect_busy("basic_commit", 1'b0);
    tick();
    expect_out("basic_after", 1'b0, 0, 1'b0);
  endtask

  // Zero mask: ready immediately, single commit pulse, no error.
  task automatic test_zero_mask();
    drive_issue(5, 8'h00);
    tick();
    expect_out("zmask_issue", 1'b0, 0, 1'b0);
    expect_busy("zmask_issue", 1'b1);
    tick();
    expect_out("zmask_commit", 1'b1, 5, 1'b0);
    tick();
    expect_out("zmask_single", 1'b0, 0, 1'b0);
    expect_busy("zmask_single", 1'b0);
  endtask

  // RR moves to 8 via a commit of 7, then 2/7/12 complete together.
  task automatic test_round_robin();
    drive_issue(7, 8'h00);
    tick();
    tick();
    expect_out("rr_setup", 1'b1, 7, 1'b0);
    drive_issue(2, 8'h01);
    tick();
    drive_issue(7, 8'h02);
    tick();
    drive_issue(12, 8'h04);
    tick();
    expect_out("rr_issued", 1'b0, 0, 1'b0);
    drive_done(0, 2);
    drive_done(1, 7);
    drive_done(2, 12);
    tick();
    expect_out("rr_done_edge", 1'b0, 0, 1'b0);
    tick();
    expect_out("rr_first", 1'b1, 12, 1'b0);
    tick();
    expect_out("rr_second", 1'b1, 2, 1'b0);
    tick();
    expect_out("rr_third", 1'b1, 7, 1'b0);
    tick();
    expect_out("rr_drained", 1'b0, 0, 1'b0);
    expect_busy("rr_drained", 1'b0);
  endtask

  // RR should now be 8: with 7 and 9 ready together, 9 goes first.
  task automatic test_back_to_back();
    drive_issue(9, 8'h01);
    tick();
    drive_issue(7, 8'h02);
    tick();
    drive_done(0, 9);
    drive_done(1, 7);
    tick();
    tick();
    expect_out("b2b_first", 1'b1, 9, 1'b0);
    tick();
    expect_out("b2b_second", 1'b1, 7, 1'b0);
    tick();
    expect_out("b2b_end", 1'b0, 0, 1'b0);
  endtask

  task automatic test_errors();
    drive_issue(4, 8'h02);
    tick();
    expect_out("err_issue4", 1'b0, 0, 1'b0);
    // Re-issue with a zero mask: if it overwrote Pending, 4 would commit.
    drive_issue(4, 8'h00);
    tick();
    expect_out("err_reissue", 1'b0, 0, 1'b1);
    tick();
    expect_out("err_reissue_nocommit", 1'b0, 0, 1'b0);
    drive_done(1, 9);
    tick();
    expect_out("err_done_invalid", 1'b0, 0, 1'b1);
    tick();
    expect_out("err_no_commit9", 1'b0, 0, 1'b0);
    // Two errors on one edge give one single-cycle pulse.
    drive_issue(4, 8'h00);
    drive_done(3, 4);
    tick();
    expect_out("err_multi", 1'b0, 0, 1'b1);
    tick();
    expect_out("err_multi_single", 1'b0, 0, 1'b0);
    // Pending for 4 was still lane1 only.
    drive_done(1, 4);
    tick();
    expect_out("err_lane1_done4", 1'b0, 0, 1'b0);
    tick();
    expect_out("err_commit4", 1'b1, 4, 1'b0);
    tick();
    // Issue and done to the same entry in one cycle: done rejected.
    drive_issue(10, 8'h01);
    drive_done(0, 10);
    tick();
    expect_out("err_same_cycle", 1'b0, 0, 1'b1);
    tick();
    expect_out("err_same_cycle_hold", 1'b0, 0, 1'b0);
    expect_busy("err_same_cycle_hold", 1'b1);
    drive_done(0, 10);
    tick();
    expect_out("err_done10", 1'b0, 0, 1'b0);
    tick();
    expect_out("err_commit10", 1'b1, 10, 1'b0);
    tick();
  endtask

  task automatic test_all_lanes();
    drive_issue(1, 8'hFF);
    tick();
    for (int l = 0; l < NUM_LANE; l++) drive_done(l, 1);
    tick();
    expect_out("all_done_edge", 1'b0, 0, 1'b0);
    tick();
    expect_out("all_commit", 1'b1, 1, 1'b0);
    drive_issue(1, 8'h00);
    tick();
    expect_out("all_reissue", 1'b0, 0, 1'b0);
    tick();
    expect_out("all_reissue_commit", 1'b1, 1, 1'b0);
    tick();
    expect_out("all_end", 1'b0, 0, 1'b0);
    expect_busy("all_end", 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 5; n++) begin
      drive_issue(n, 8'h01);
      tick();
    end
    drive_issue(5, 8'h00);
    tick();
    expect_busy("rmid_busy", 1'b1);
    // Entry 5 would be granted at this edge; reset discards it.
    reset = 1'b1;
    tick();
    n_tests++;
    if ({bus.O_Req_Commit, bus.O_CommitNo, bus.O_Busy, bus.O_Err} !== '0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got commit=%b no=%0d busy=%b err=%b want all 0",
               bus.O_Req_Commit, bus.O_CommitNo, bus.O_Busy, bus.O_Err);
    end
    reset = 1'b0;
    tick();
    expect_out("rmid_after", 1'b0, 0, 1'b0);
    drive_done(0, 0);
    drive_done(1, 2);
    tick();
    expect_out("rmid_stale_done", 1'b0, 0, 1'b1);
    tick();
    expect_out("rmid_no_commit", 1'b0, 0, 1'b0);
    tick();
    expect_out("rmid_quiet", 1'b0, 0, 1'b0);
    expect_busy("rmid_quiet", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_mask();
    test_round_robin();
    test_back_to_back();
    test_errors();
    test_all_lanes();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/commit_agg_mpu.md
# commit_agg_mpu

Commit aggregator for the MPU. It sits directly upstream of the MPU commit table and downstream of the lane/TPU completion paths. For every issued instruction it tracks which lanes still owe a completion. Once all targeted lanes have reported, it emits exactly one commit request carrying that instruction's issue number, at most one per cycle, in round-robin order among completed entries.

## Interface
Parameters:
- NUM_ENTRY, default 16: tracked issue numbers; must equal the MPU hazard-table depth; power of two.
- NUM_LANE, default 8: number of completion-reporting lanes.
- WIDTH_NO, default $clog2(NUM_ENTRY): issue-number width (mpu_issue_no_t).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- I_Req_Issue  in  1  dispatch registers a new instruction this cycle.
- I_Issue_No  in  WIDTH_NO  issue number being registered.
- I_Lane_Mask  in  NUM_LANE  lanes that must report completion for I_Issue_No.
- I_Lane_Done  in  NUM_LANE  per-lane completion strobe.
- I_Lane_No  in  NUM_LANE x WIDTH_NO  per-lane issue number being completed.
- O_Req_Commit  out  1  one-cycle commit request to the commit table.
- O_CommitNo  out  WIDTH_NO  issue number committed; valid while O_Req_Commit=1.
- O_Busy  out  1  at least one entry is outstanding.
- O_Err  out  1  one-cycle protocol-error pulse.

## Operation
- State per entry i: Valid[i] and Pending[i][NUM_LANE-1:0]. Also a round-robin pointer RR (WIDTH_NO), R_Commit, R_CommitNo and R_Err.
- Issue: if I_Req_Issue=1 and Valid[I_Issue_No]=0, set Valid<=1 and Pending<=I_Lane_Mask. A zero mask is legal; the entry becomes ready immediately.
- Issue to an entry with Valid=1: the issue is ignored, the entry is unchanged, and O_Err pulses.
- Done: for each lane L with I_Lane_Done[L]=1, clear Pending[I_Lane_No[L]][L]. Several lanes may complete the same or different entries in one cycle; all clears apply together.
- Done for an entry with Valid=0, or for a lane bit that is already 0: ignored and O_Err pulses. Multiple errors in one cycle give a single pulse.
- Issue and done hitting the same entry in the same cycle: Valid was 0 before the edge, so the done is an error and is ignored. The issue proceeds.
- Ready[i] = Valid[i] & (Pending[i]==0), evaluated from registered state.
- Grant: the first ready entry searched from RR upward with wrap-around (RR, RR+1, ..., NUM_ENTRY-1, 0, ..., RR-1). On grant:
  - Valid[g]<=0.
  - R_Commit<=1 and R_CommitNo<=g.
  - RR<=g+1, modulo NUM_ENTRY.
- With no grant, R_Commit<=0; R_CommitNo and RR hold.
- A granted entry may be re-issued from the cycle after its grant edge.
- O_Busy = OR of Valid.
- Reset values: O_Req_Commit=0, O_CommitNo=0, O_Err=0, O_Busy=0, RR=0, all Valid=0, all Pending=0.

## Timing
- Latency is 2 cycles. Completing done sampled at edge k clears Pending at edge k. Ready is combinational in cycle k..k+1, the grant registers at edge k+1, and O_Req_Commit is high for one cycle after edge k+1.
- A zero-mask issue sampled at edge k also gives O_Req_Commit high after edge k+1.
- Throughput: one commit per cycle. N simultaneously ready entries produce N consecutive commit pulses.
- O_Err is registered and is high for the cycle after the offending edge.
- No backpressure: the commit table always accepts O_Req_Commit. Commit order may differ from issue order; the downstream table reorders.
- Reset asserted mid-operation discards all outstanding entries and any pending grant. Outputs are 0 from the first clock edge with reset=1 onward.

## Test plan
- Issue No=3 with Mask=8'h05. Lane0 done No=3, then two cycles later lane2 done No=3 -> O_Req_Commit=1, O_CommitNo=3 exactly 2 cycles after the lane2 done edge. O_Busy=0 the following cycle.
- Issue No=5 with Mask=0 -> single commit pulse with O_CommitNo=5, 2 cycles after the issue edge. No O_Err.
- Entries 2, 7 and 12 become complete on the same edge with RR=8 -> commits in order 12, 2, 7 on three consecutive cycles. RR ends at 8.
- Re-issue No=4 while it is still Valid, and lane1 done for invalid No=9 -> O_Err pulses. Entry 4's Pending is unchanged. No commit for 9.
- Lanes 0-7 all report done for No=1 (Mask=8'hFF) in one cycle -> one commit of No=1. No=1 is re-issued the next cycle and is accepted without O_Err.
- Six entries outstanding, then reset high for one cycle -> all outputs 0. Later dones for those numbers raise O_Err and produce no commits.
